// File: rtl/whack_round_controller_if.sv
// Button/hit inputs and game-status outputs shared between the round controller
// and the surrounding mole generator, hit logic and timer display.
interface whack_round_controller_if #(
   parameter int NUM_LEVELS = 4
) ();
   localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

   logic             start_pressed;
   logic             pause_pressed;
   logic             hit;
   logic             game_in_progress;
   logic             paused;
   logic             mole_up;
   logic             mole_clk;
   logic             game_over;
   logic [6:0]       seconds_left;
   logic [LVL_W-1:0] level;

   modport master (
      input  start_pressed, pause_pressed, hit,
      output game_in_progress, paused, mole_up, mole_clk, game_over,
             seconds_left, level
   );

   modport slave (
      output start_pressed, pause_pressed, hit,
      input  game_in_progress, paused, mole_up, mole_clk, game_over,
             seconds_left, level
   );
endinterface

// File: rtl/whack_round_controller.sv
// Whac-A-Mole round controller: game timer, mole up/down phase timing with
// hit-driven difficulty levels, and pause/resume.
module whack_round_controller #(
   parameter int CLK_PER_MS          = 50000,
   parameter int GAME_LENGTH_SECONDS = 20,
   parameter int MOLE_UP_MS_INIT     = 1000,
   parameter int MOLE_DOWN_MS_INIT   = 1000,
   parameter int MOLE_MS_STEP        = 100,
   parameter int MOLE_MS_MIN         = 300,
   parameter int LEVEL_UP_HITS       = 8,
   parameter int NUM_LEVELS          = 4
) (
   input logic                      clk,
   input logic                      rst,
   whack_round_controller_if.master bus
);
   localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

   localparam logic [15:0]      CLK_LAST  = 16'(CLK_PER_MS - 1);
   localparam logic [15:0]      SEC_LAST  = 16'd999;
   localparam logic [15:0]      UP_INIT   = 16'(MOLE_UP_MS_INIT);
   localparam logic [15:0]      DN_INIT   = 16'(MOLE_DOWN_MS_INIT);
   localparam logic [15:0]      MS_STEP   = 16'(MOLE_MS_STEP);
   localparam logic [15:0]      MS_MIN    = 16'(MOLE_MS_MIN);
   localparam logic [15:0]      HITS_LAST = 16'(LEVEL_UP_HITS - 1);
   localparam logic [6:0]       SECS_INIT = 7'(GAME_LENGTH_SECONDS);
   localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(NUM_LEVELS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_UP, S_DOWN, S_PAUSED, S_OVER
   } state_t;

   state_t           state_q, state_d, ret_q, ret_d, nxt;
   logic [15:0]      presc_q, presc_d;
   logic [15:0]      sec_ms_q, sec_ms_d;
   logic [15:0]      phase_ms_q, phase_ms_d;
   logic [15:0]      hit_cnt_q, hit_cnt_d;
   logic [15:0]      up_len_q, up_len_d;
   logic [15:0]      dn_len_q, dn_len_d;
   logic [15:0]      cur_len_q, cur_len_d;
   logic [6:0]       secs_q, secs_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             mole_clk_q, mole_clk_d;
   logic             game_over_q, game_over_d;

   logic running, ms_tick, sec_wrap, game_end, phase_end;

   // Shorten a phase by one step, never going below the floor.
   function automatic logic [15:0] shorten(input logic [15:0] len);
      if ({1'b0, len} < ({1'b0, MS_MIN} + {1'b0, MS_STEP}))
         return MS_MIN;
      return len - MS_STEP;
   endfunction

   assign running   = (state_q == S_UP) || (state_q == S_DOWN);
   assign ms_tick   = running && (presc_q == CLK_LAST);
   assign sec_wrap  = ms_tick && (sec_ms_q == SEC_LAST);
   assign game_end  = sec_wrap && (secs_q == 7'd1);
   assign phase_end = ms_tick && (phase_ms_q == cur_len_q - 16'd1);

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      nxt         = state_q;
      presc_d     = presc_q;
      sec_ms_d    = sec_ms_q;
      phase_ms_d  = phase_ms_q;
      hit_cnt_d   = hit_cnt_q;
      up_len_d    = up_len_q;
      dn_len_d    = dn_len_q;
      cur_len_d   = cur_len_q;
      secs_d      = secs_q;
      level_d     = level_q;
      mole_clk_d  = 1'b0;
      game_over_d = 1'b0;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (bus.start_pressed) begin
               state_d    = S_UP;
               secs_d     = SECS_INIT;
               level_d    = '0;
               up_len_d   = UP_INIT;
               dn_len_d   = DN_INIT;
               cur_len_d  = UP_INIT;
               presc_d    = '0;
               sec_ms_d   = '0;
               phase_ms_d = '0;
               hit_cnt_d  = '0;
               mole_clk_d = 1'b1;
            end
         end
         S_UP, S_DOWN: begin
            presc_d = ms_tick ? 16'd0 : presc_q + 16'd1;
            if (ms_tick) begin
               sec_ms_d   = sec_wrap  ? 16'd0 : sec_ms_q + 16'd1;
               phase_ms_d = phase_end ? 16'd0 : phase_ms_q + 16'd1;
            end
            if (sec_wrap)
               secs_d = secs_q - 7'd1;

            if ((state_q == S_UP) && bus.hit) begin
               if (hit_cnt_q == HITS_LAST) begin
                  hit_cnt_d = '0;
                  if (level_q < LVL_MAX) begin
                     level_d  = level_q + 1'b1;
                     up_len_d = shorten(up_len_q);
                     dn_len_d = shorten(dn_len_q);
                  end
               end else begin
                  hit_cnt_d = hit_cnt_q + 16'd1;
               end
            end

            // A phase switch loads the freshly updated lengths, so a level-up on
            // the expiry cycle already applies to the phase being entered.
            if (phase_end) begin
               nxt       = (state_q == S_UP) ? S_DOWN : S_UP;
               cur_len_d = (nxt == S_UP) ? up_len_d : dn_len_d;
            end

            if (game_end) begin
               state_d     = S_OVER;
               game_over_d = 1'b1;
            end else begin
               mole_clk_d = phase_end && (nxt == S_UP);
               if (bus.pause_pressed) begin
                  ret_d   = nxt;
                  state_d = S_PAUSED;
               end else begin
                  state_d = nxt;
               end
            end
         end
         S_PAUSED: begin
            if (bus.pause_pressed)
               state_d = ret_q;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ret_q       <= S_UP;
         presc_q     <= '0;
         sec_ms_q    <= '0;
         phase_ms_q  <= '0;
         hit_cnt_q   <= '0;
         up_len_q    <= UP_INIT;
         dn_len_q    <= DN_INIT;
         cur_len_q   <= UP_INIT;
         secs_q      <= SECS_INIT;
         level_q     <= '0;
         mole_clk_q  <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         presc_q     <= presc_d;
         sec_ms_q    <= sec_ms_d;
         phase_ms_q  <= phase_ms_d;
         hit_cnt_q   <= hit_cnt_d;
         up_len_q    <= up_len_d;
         dn_len_q    <= dn_len_d;
         cur_len_q   <= cur_len_d;
         secs_q      <= secs_d;
         level_q     <= level_d;
         mole_clk_q  <= mole_clk_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.game_in_progress = running || (state_q == S_PAUSED);
   assign bus.paused           = (state_q == S_PAUSED);
   assign bus.mole_up          = (state_q == S_UP);
   assign bus.mole_clk         = mole_clk_q;
   assign bus.game_over        = game_over_q;
   assign bus.seconds_left     = secs_q;
   assign bus.level            = level_q;
endmodule

// File: tb/tb_whack_round_controller.sv
// Bench for whack_round_controller: directed game scenarios plus random
// start/pause/hit traffic checked against a cycle-count based game model.
module tb_whack_round_controller;
   localparam int CPM  = 2;
   localparam int GL   = 2;
   localparam int UPI  = 4;
   localparam int DNI  = 4;
   localparam int STEP = 1;
   localparam int MIN  = 2;
   localparam int LUH  = 2;
   localparam int NL   = 4;

   localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_PS = 3, M_OVER = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   whack_round_controller_if #(.NUM_LEVELS(NL)) bus ();

   whack_round_controller #(
      .CLK_PER_MS(CPM), .GAME_LENGTH_SECONDS(GL),
      .MOLE_UP_MS_INIT(UPI), .MOLE_DOWN_MS_INIT(DNI),
      .MOLE_MS_STEP(STEP), .MOLE_MS_MIN(MIN),
      .LEVEL_UP_HITS(LUH), .NUM_LEVELS(NL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Game model: time is tracked as running cycles since start; seconds and
   // phase boundaries follow from plain division and differences.
   int m_st, m_ret, m_run, m_ph_start, m_ph_len, m_up, m_dn, m_lvl, m_hits, m_secs;
   int m_mclk, m_gov;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int shorter(input int len);
      return (len - STEP < MIN) ? MIN : len - STEP;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_ret = M_UP; m_run = 0; m_ph_start = 0; m_ph_len = UPI;
      m_up = UPI; m_dn = DNI; m_lvl = 0; m_hits = 0; m_secs = GL;
      m_mclk = 0; m_gov = 0;
   endtask

   task automatic model_step(input bit s, input bit p, input bit h);
      int  nxt;
      bit  expd;
      m_mclk = 0;
      m_gov  = 0;
      if (m_st == M_IDLE || m_st == M_OVER) begin
         if (s) begin
            m_st = M_UP; m_run = 0; m_ph_start = 0; m_ph_len = UPI;
            m_up = UPI; m_dn = DNI; m_lvl = 0; m_hits = 0; m_secs = GL;
            m_mclk = 1;
         end
      end else if (m_st == M_PS) begin
         if (p) m_st = m_ret;
      end else begin
         m_run++;
         m_secs = GL - m_run / (CPM * 1000);
         if (m_st == M_UP && h) begin
            m_hits++;
            if (m_hits == LUH) begin
               m_hits = 0;
               if (m_lvl < NL - 1) begin
                  m_lvl++;
                  m_up = shorter(m_up);
                  m_dn = shorter(m_dn);
               end
            end
         end
         nxt  = m_st;
         expd = ((m_run - m_ph_start) == m_ph_len * CPM);
         if (expd) begin
            nxt        = (m_st == M_UP) ? M_DN : M_UP;
            m_ph_start = m_run;
            m_ph_len   = (nxt == M_UP) ? m_up : m_dn;
         end
         if (m_secs == 0) begin
            m_st  = M_OVER;
            m_gov = 1;
         end else begin
            m_mclk = (expd && nxt == M_UP) ? 1 : 0;
            if (p) begin
               m_ret = nxt;
               m_st  = M_PS;
            end else begin
               m_st = nxt;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk("game_in_progress", bus.game_in_progress,
          (m_st == M_UP || m_st == M_DN || m_st == M_PS));
      chk("paused", bus.paused, (m_st == M_PS));
      chk("mole_up", bus.mole_up, (m_st == M_UP));
      chk("mole_clk", bus.mole_clk, m_mclk);
      chk("game_over", bus.game_over, m_gov);
      chk("seconds_left", bus.seconds_left, m_secs);
      chk("level", bus.level, m_lvl);
   endtask

   task automatic step(input bit s, input bit p, input bit h);
      bus.start_pressed = s;
      bus.pause_pressed = p;
      bus.hit           = h;
      @(posedge clk);
      model_step(s, p, h);
      #1;
      check_outputs();
      bus.start_pressed = 1'b0;
      bus.pause_pressed = 1'b0;
      bus.hit           = 1'b0;
   endtask

   // Reset asserted between clock edges; outputs must clear immediately.
   task automatic do_reset();
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      chk("rst_seconds", bus.seconds_left, GL);
      chk("rst_level", bus.level, 0);
      chk("rst_mole_up", bus.mole_up, 0);
      chk("rst_game_over", bus.game_over, 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   task automatic hit_until_level(input int lvl, input string tag);
      for (int i = 0; i < 600 && m_lvl < lvl; i++) step(0, 0, m_st == M_UP);
      if (m_lvl < lvl) chk(tag, 0, 1);
   endtask

   task automatic measure_next_up(input int exp_cycles, input string tag);
      bit found = 0;
      int len   = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(0, 0, 0);
         if (bus.mole_clk) found = 1;
      end
      if (!found) chk({tag, "_timeout"}, 0, 1);
      else begin
         len = 1;
         for (int i = 0; i < 100 && bus.mole_up; i++) begin
            step(0, 0, 0);
            if (bus.mole_up) len++;
         end
         chk(tag, len, exp_cycles);
      end
   endtask

   initial begin
      int sec_hold, lvl_hold;
      bus.start_pressed = 1'b0;
      bus.pause_pressed = 1'b0;
      bus.hit           = 1'b0;
      model_reset();
      #12;
      rst = 1'b0;
      #1;
      check_outputs();
      chk("reset_seconds", bus.seconds_left, GL);
      chk("reset_gip", bus.game_in_progress, 0);

      // Full game without hits, checked against closed-form timing too.
      step(0, 1, 0);
      chk("pause_in_idle", bus.paused, 0);
      step(1, 0, 0);
      chk("first_mole_clk", bus.mole_clk, 1);
      for (int k = 1; k <= 4000; k++) begin
         step(k == 100, 0, 0);
         chk("cf_mole_clk", bus.mole_clk, (k % 16 == 0 && k < 4000));
         chk("cf_seconds", bus.seconds_left, GL - k / 2000);
         chk("cf_game_over", bus.game_over, (k == 4000));
      end
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0);
         chk("over_gip", bus.game_in_progress, 0);
         chk("over_pulse_once", bus.game_over, 0);
      end

      // Restart from GAME_OVER and level-up / clamp behaviour.
      step(1, 0, 0);
      chk("restart_seconds", bus.seconds_left, GL);
      chk("restart_level", bus.level, 0);
      chk("restart_mole_clk", bus.mole_clk, 1);
      hit_until_level(1, "reach_level1_timeout");
      measure_next_up(6, "up_len_level1");
      hit_until_level(2, "reach_level2_timeout");
      for (int i = 0; i < 50 && m_st != M_UP; i++) step(0, 0, 0);
      chk("level2_in_up", bus.mole_up, 1);
      do_reset();
      step(1, 0, 0);
      chk("post_rst_level", bus.level, 0);
      hit_until_level(3, "reach_level3_timeout");
      measure_next_up(4, "up_len_clamped");
      for (int i = 0; i < 40; i++) step(0, 0, m_st == M_UP);
      chk("level_saturated", bus.level, 3);

      // Pause mid-phase for 500 cycles with hits and starts thrown at it.
      do_reset();
      step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 0);
      step(0, 0, 0);
      sec_hold = bus.seconds_left;
      lvl_hold = bus.level;
      step(0, 1, 0);
      chk("paused_entered", bus.paused, 1);
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 9) == 0, 0, $urandom_range(0, 1) == 1);
         chk("pause_mole_clk", bus.mole_clk, 0);
         chk("pause_seconds", bus.seconds_left, sec_hold);
         chk("pause_level", bus.level, lvl_hold);
      end
      step(0, 1, 0);
      chk("resume_mole_up", bus.mole_up, 1);
      chk("resume_no_mole_clk", bus.mole_clk, 0);
      step(0, 0, 1);
      chk("hit_count_kept", bus.level, 1);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 7999) == 0) do_reset();
         else step($urandom_range(0, 399) == 0, $urandom_range(0, 149) == 0,
                   $urandom_range(0, 5) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/whack_round_controller.md
Name: whack_round_controller

Overview:
Parametrised next-generation game controller for Whac-A-Mole. It owns the game timer, the mole up/down phase timing and a new difficulty-level mechanism: mole phases shorten after every LEVEL_UP_HITS hits. It adds pause/resume. It sits between the debounced start/pause buttons and the mole generator, hit logic and timer display, replacing the separate FSM and timer pair.

Parameters:
CLK_PER_MS, 50000, clk cycles per millisecond tick
GAME_LENGTH_SECONDS, 20, game duration in seconds (1..99)
MOLE_UP_MS_INIT, 1000, level-0 mole-up phase length in ms
MOLE_DOWN_MS_INIT, 1000, level-0 mole-down phase length in ms
MOLE_MS_STEP, 100, ms removed from both phases per level-up
MOLE_MS_MIN, 300, floor for both phase lengths in ms
LEVEL_UP_HITS, 8, accepted hits needed per level-up
NUM_LEVELS, 4, number of levels; level saturates at NUM_LEVELS-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_pressed  in  1  one-cycle pulse, debounced start button
pause_pressed  in  1  one-cycle pulse, debounced pause button
hit  in  1  one-cycle pulse from hit logic on a correct whack
game_in_progress  out  1  high in MOLE_UP, MOLE_DOWN, PAUSED
paused  out  1  high in PAUSED
mole_up  out  1  high in MOLE_UP
mole_clk  out  1  one-cycle pulse on every entry to MOLE_UP (new mole set)
game_over  out  1  one-cycle pulse on entry to GAME_OVER
seconds_left  out  7  remaining seconds, binary
level  out  clog2(NUM_LEVELS) bits  current difficulty level

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except seconds_left = GAME_LENGTH_SECONDS. Prescaler, ms, hit counters 0. Phase lengths = INIT values.
- Prescaler: counts 0..CLK_PER_MS-1 and emits ms_tick on wrap. It runs only in MOLE_UP/MOLE_DOWN and is held (not cleared) in PAUSED.
- sec_ms counter: counts ms_tick 0..999. On wrap, seconds_left decrements.
- phase_ms counter: counts ms_tick up to the current phase length, then switches phase.
- States:
  - IDLE: on start_pressed, load seconds_left = GAME_LENGTH_SECONDS, level = 0, phases = INIT, clear counters, go to MOLE_UP. mole_clk pulses the cycle after start_pressed.
  - MOLE_UP: on phase expiry, go to MOLE_DOWN.
  - MOLE_DOWN: on phase expiry, go to MOLE_UP and pulse mole_clk.
  - MOLE_UP/MOLE_DOWN: on pause_pressed, save the return state and go to PAUSED. All counters freeze.
  - PAUSED: on pause_pressed, return to the saved state and counters continue. No mole_clk pulse on resume. Hits are ignored.
  - Any running state: on the decrement that makes seconds_left 0, go to GAME_OVER, pulse game_over, drop game_in_progress.
  - GAME_OVER: seconds_left holds 0 and level holds. start_pressed restarts exactly as from IDLE.
- Hits: counted only in MOLE_UP.
  - When the hit count reaches LEVEL_UP_HITS, it clears to 0.
  - If level < NUM_LEVELS-1: level increments and both phase lengths drop by MOLE_MS_STEP, clamped at MOLE_MS_MIN.
  - At the top level, hits wrap with no change.
  - New lengths take effect at the next phase load; the current phase is not cut short.
- Priority in one cycle: rst > expiry to GAME_OVER > pause > phase expiry.
  - Game expiry and phase expiry together: GAME_OVER, no mole_clk.
  - Pause and phase expiry together: enter PAUSED with the return state = post-expiry state, and any due mole_clk is still emitted.
  - start_pressed while running or paused: ignored.
  - pause_pressed in IDLE or GAME_OVER: ignored.
- Widths: phase lengths and counters are 16 bits. MOLE_MS_MIN ≤ INIT values is a parameter constraint.
- Reset mid-game: immediate IDLE. No game_over pulse.

Test Plan:
- CLK_PER_MS=2, GAME_LENGTH_SECONDS=2, UP=DOWN=4ms: pulse start.
  - mole_clk pulses the next cycle, then every 16 cycles.
  - seconds_left goes 2→1 at cycle 2000 and 1→0 at cycle 4000.
  - game_over pulses once and game_in_progress falls.
- Level-up, LEVEL_UP_HITS=2, STEP=1, MIN=2: two hits in MOLE_UP → level 1.
  - Next MOLE_UP lasts 3ms (6 cycles).
  - Repeated level-ups clamp at 2ms, and level saturates at 3.
- Pause at mid-phase: hold 500 cycles, then resume.
  - seconds_left, mole phase and hit count are unchanged across the pause.
  - No mole_clk fires on resume; hits during the pause are ignored.
- Simultaneous events:
  - Final second and phase expiry in the same cycle → GAME_OVER, no mole_clk.
  - start during the game is ignored.
  - pause in IDLE is ignored.
- Async rst asserted mid-MOLE_UP at level 2 → outputs return to reset values on the same edge with no game_over pulse. After release, start begins at level 0.
- In GAME_OVER, start_pressed → seconds_left reloads to GAME_LENGTH_SECONDS, level returns to 0 and mole_clk pulses.
